nebula_reasm_vc_scheduler: RTL and testbench



---
 rtl/nebula_reasm_vc_scheduler_pkg.sv | 38 +++
 rtl/nebula_reasm_vc_scheduler_arb.sv | 41 ++++
 rtl/nebula_reasm_vc_scheduler.sv | 140 ++++++++++++++
 tb/tb_nebula_reasm_vc_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nebula_reasm_vc_scheduler_pkg.sv
// Shared NoC flit format, flit-type constants and error codes for the
// ejection-side VC scheduler and its QoS round-robin arbiter.
package nebula_reasm_vc_scheduler_pkg;

    localparam int QOS_W     = 2;
    localparam int PAYLOAD_W = 32;

    localparam logic [1:0] FLIT_TYPE_HEAD   = 2'b00;
    localparam logic [1:0] FLIT_TYPE_BODY   = 2'b01;
    localparam logic [1:0] FLIT_TYPE_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

    typedef struct packed {
        logic [1:0]           flit_type;
        logic [QOS_W-1:0]     qos;
        logic [PAYLOAD_W-1:0] payload;
    } noc_flit_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PROTOCOL = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } error_code_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_e;

    function automatic logic is_packet_start(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_HEAD) || (flit_type == FLIT_TYPE_SINGLE);
    endfunction

    function automatic logic is_packet_end(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_TAIL) || (flit_type == FLIT_TYPE_SINGLE);
    endfunction

endpackage

// File: rtl/nebula_reasm_vc_scheduler_arb.sv
// Combinational QoS-first arbiter: highest qos wins, ties go to the first
// requester at or after rr_ptr in increasing index order (mod N).
module nebula_qos_rr_arbiter #(
    parameter  int N  = 4,
    parameter  int QW = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [N*QW-1:0] i_qos,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic [IW-1:0]   o_gnt_idx,
    output logic            o_gnt_any
);

    logic [QW-1:0] w_qos_arr [N];
    logic [QW-1:0] w_best;
    logic [IW-1:0] w_idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_qos_arr[i] = i_qos[i*QW +: QW];
        end
    end

    // Strict '>' keeps the earliest rotated requester on a qos tie.
    always_comb begin
        o_gnt_any = 1'b0;
        o_gnt_idx = '0;
        w_best    = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((int'(i_rr_ptr) + k) % N);
            if (i_req[w_idx] && (!o_gnt_any || (w_qos_arr[w_idx] > w_best))) begin
                o_gnt_any = 1'b1;
                o_gnt_idx = w_idx;
                w_best    = w_qos_arr[w_idx];
            end
        end
    end

endmodule

// File: rtl/nebula_reasm_vc_scheduler.sv
// Shares one packet disassembler between NUM_VCS ejection VC queues with
// wormhole-locked QoS/round-robin grants, stray-flit discard and a watchdog.
module nebula_reasm_vc_scheduler
    import nebula_reasm_vc_scheduler_pkg::*;
#(
    parameter  int NUM_VCS        = 4,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int VC_W           = $clog2(NUM_VCS),
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_VCS-1:0]        i_in_valid,
    input  noc_flit_t [NUM_VCS-1:0]   i_in_flit,
    output logic [NUM_VCS-1:0]        o_in_ready,
    output logic                      o_out_valid,
    output noc_flit_t                 o_out_flit,
    input  logic                      i_out_ready,
    output logic [VC_W-1:0]           o_grant_vc,
    output logic                      o_busy,
    output logic                      o_abort,
    output logic                      o_err_valid,
    output error_code_e               o_err_code
);

    sched_state_e          r_state;
    logic [VC_W-1:0]       r_rr_ptr;
    logic [VC_W-1:0]       r_grant;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_abort;
    logic                  r_err_valid;
    error_code_e           r_err_code;

    logic [NUM_VCS-1:0]       w_cand;
    logic [NUM_VCS-1:0]       w_stray;
    logic [NUM_VCS*QOS_W-1:0] w_qos;
    logic [VC_W-1:0]          w_gnt_idx;
    logic                     w_gnt_any;
    logic                     w_locked;
    logic                     w_sel_valid;
    noc_flit_t                w_sel_flit;
    logic                     w_accept;
    logic [VC_W-1:0]          w_next_rr;

    // Stray discards are gated by rst_n so nothing is popped while in reset.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_cand[v]                 = i_in_valid[v] & is_packet_start(i_in_flit[v].flit_type);
            w_stray[v]                = i_in_valid[v] & ~is_packet_start(i_in_flit[v].flit_type) & rst_n;
            w_qos[v*QOS_W +: QOS_W]   = i_in_flit[v].qos;
        end
    end

    nebula_qos_rr_arbiter #(
        .N  (NUM_VCS),
        .QW (QOS_W)
    ) u_arb (
        .i_req     (w_cand),
        .i_qos     (w_qos),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign w_locked    = (r_state == ST_LOCKED);
    assign w_sel_valid = i_in_valid[r_grant];
    assign w_sel_flit  = i_in_flit[r_grant];
    assign w_accept    = w_locked & w_sel_valid & i_out_ready;
    assign w_next_rr   = (r_grant == VC_W'(NUM_VCS - 1)) ? '0 : r_grant + 1'b1;

    assign o_out_valid = w_locked & w_sel_valid;
    assign o_out_flit  = w_locked ? w_sel_flit : '0;
    assign o_grant_vc  = r_grant;
    assign o_busy      = w_locked;
    assign o_abort     = r_abort;
    assign o_err_valid = r_err_valid;
    assign o_err_code  = r_err_code;

    always_comb begin
        o_in_ready = '0;
        if (w_locked) begin
            o_in_ready[r_grant] = i_out_ready;
        end else begin
            o_in_ready = w_stray;
        end
    end

    // Pulses default low each cycle; the timer only advances while the
    // locked VC is empty, so disassembler backpressure never aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_timer     <= '0;
            r_abort     <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_abort     <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (|w_stray) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_PROTOCOL;
                    end
                    if (w_gnt_any) begin
                        r_grant <= w_gnt_idx;
                        r_timer <= '0;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (is_packet_end(w_sel_flit.flit_type)) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_rr;
                        end
                    end else if (!w_sel_valid) begin
                        if (r_timer >= TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state     <= ST_IDLE;
                            r_rr_ptr    <= w_next_rr;
                            r_timer     <= '0;
                            r_abort     <= 1'b1;
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_TIMEOUT;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nebula_reasm_vc_scheduler.sv
// Scoreboard bench for the VC scheduler: queued per-VC sources, a packet-level
// reference model filling expected queues, and a negedge monitor.
module tb_nebula_reasm_vc_scheduler;
    import nebula_reasm_vc_scheduler_pkg::*;

    localparam int NV = 4;
    localparam int TO = 256;

    typedef struct {
        noc_flit_t flit;
        int        vc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NV-1:0]        in_valid;
    noc_flit_t [NV-1:0]   in_flit;
    logic [NV-1:0]        in_ready;
    logic                 out_valid;
    noc_flit_t            out_flit;
    logic                 out_ready;
    logic [1:0]           grant_vc;
    logic                 busy;
    logic                 abort;
    logic                 err_valid;
    error_code_e          err_code;

    exp_t         exp_q[$];
    error_code_e  exp_err[$];
    noc_flit_t    src_q[NV][$];
    noc_flit_t    mq[NV][$];
    int           acc_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           abort_cyc = -1;
    int           model_rr = 0;
    bit           rand_ready = 0;
    exp_t         mon_e;
    error_code_e  mon_ec;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nebula_reasm_vc_scheduler #(
        .NUM_VCS        (NV),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .i_in_flit   (in_flit),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_flit  (out_flit),
        .i_out_ready (out_ready),
        .o_grant_vc  (grant_vc),
        .o_busy      (busy),
        .o_abort     (abort),
        .o_err_valid (err_valid),
        .o_err_code  (err_code)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted flit and every error pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_flit: got 0x%0h, expected none", out_flit);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("out_flit", 64'(out_flit), 64'(mon_e.flit));
                    checkOutput("grant_vc", 64'(grant_vc), 64'(mon_e.vc));
                end
            end
            if (err_valid) begin
                if (exp_err.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_err: got code %0d, expected no error", err_code);
                end else begin
                    mon_ec = exp_err.pop_front();
                    checkOutput("err_code", 64'(err_code), 64'(mon_ec));
                    checkOutput("abort_with_err", 64'(abort), 64'(mon_ec == ERR_TIMEOUT));
                    if (mon_ec == ERR_TIMEOUT) abort_cyc = cyc;
                end
            end else if (abort) begin
                checks++;
                errors++;
                $display("[TB] FAIL abort_without_err: got abort=1, expected 0");
            end
        end
    end

    task automatic driveInputs();
        for (int v = 0; v < NV; v++) begin
            if (src_q[v].size() > 0) begin
                in_valid[v] = 1'b1;
                in_flit[v]  = src_q[v][0];
            end else begin
                in_valid[v] = 1'b0;
                in_flit[v]  = '0;
            end
        end
    endtask

    // One clock: sample handshakes at negedge, pop and re-drive after posedge.
    task automatic tick();
        logic [NV-1:0] fire;
        @(negedge clk);
        fire = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int v = 0; v < NV; v++) begin
            if (fire[v] && src_q[v].size() > 0) void'(src_q[v].pop_front());
        end
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        driveInputs();
    endtask

    function automatic logic [1:0] typeFor(input int idx, input int len);
        if (len == 1) return FLIT_TYPE_SINGLE;
        if (idx == 0) return FLIT_TYPE_HEAD;
        if (idx == len - 1) return FLIT_TYPE_TAIL;
        return FLIT_TYPE_BODY;
    endfunction

    task automatic applyStimulus(input int v, input int len, input int qos);
        noc_flit_t f;
        for (int i = 0; i < len; i++) begin
            f.flit_type = typeFor(i, len);
            f.qos       = QOS_W'(qos);
            f.payload   = $urandom;
            src_q[v].push_back(f);
            mq[v].push_back(f);
        end
    endtask

    // Reference: among VCs with a waiting packet take the highest head qos;
    // among those, the first one reached walking upward from the rr pointer.
    task automatic modelResolve();
        int  top_qos;
        int  win;
        bit  any;
        exp_t e;
        forever begin
            any = 0;
            top_qos = -1;
            for (int v = 0; v < NV; v++) begin
                if (mq[v].size() > 0) begin
                    any = 1;
                    if (int'(mq[v][0].qos) > top_qos) top_qos = int'(mq[v][0].qos);
                end
            end
            if (!any) break;
            win = -1;
            for (int k = 0; k < NV && win < 0; k++) begin
                int v;
                v = (model_rr + k) % NV;
                if (mq[v].size() > 0 && int'(mq[v][0].qos) == top_qos) win = v;
            end
            forever begin
                e.flit = mq[win].pop_front();
                e.vc   = win;
                exp_q.push_back(e);
                if (e.flit.flit_type == FLIT_TYPE_TAIL || e.flit.flit_type == FLIT_TYPE_SINGLE) break;
            end
            model_rr = (win + 1) % NV;
        end
    endtask

    function automatic bit srcPending();
        for (int v = 0; v < NV; v++) if (src_q[v].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || exp_err.size() > 0 || srcPending()) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({"drain_", name}, 64'(n < budget), 64'(1));
        if (n >= budget) begin
            exp_q.delete();
            exp_err.delete();
            for (int v = 0; v < NV; v++) src_q[v].delete();
            driveInputs();
        end
        repeat (2) tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        checkOutput({tag, "_abort"}, 64'(abort), 64'(0));
        checkOutput({tag, "_err_valid"}, 64'(err_valid), 64'(0));
        checkOutput({tag, "_err_code"}, 64'(err_code), 64'(ERR_NONE));
        checkOutput({tag, "_grant_vc"}, 64'(grant_vc), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int        load_cyc;
        int        unstable;
        noc_flit_t head;
        noc_flit_t f;
        exp_t      e;

        in_valid  = '0;
        in_flit   = '0;
        out_ready = 1'b0;
        #12;
        checkResetOutputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single VC, three flits, one-cycle arbitration bubble.
        out_ready = 1'b1;
        acc_cyc.delete();
        load_cyc = cyc;
        applyStimulus(2, 3, 1);
        modelResolve();
        driveInputs();
        drain(50, "single_vc");
        checkOutput("single_vc_count", 64'(acc_cyc.size()), 64'(3));
        if (acc_cyc.size() == 3) begin
            checkOutput("arb_bubble", 64'(acc_cyc[0] - load_cyc), 64'(1));
            checkOutput("body_back_to_back", 64'(acc_cyc[1] - acc_cyc[0]), 64'(1));
            checkOutput("tail_back_to_back", 64'(acc_cyc[2] - acc_cyc[1]), 64'(1));
        end
        checkOutput("busy_after_tail", 64'(busy), 64'(0));

        // rr pointer now 3: VC3 should win the tie against VC0.
        applyStimulus(0, 1, 0);
        applyStimulus(3, 1, 0);
        modelResolve();
        driveInputs();
        drain(50, "rr_after_release");

        // QoS beats round-robin.
        applyStimulus(0, 2, 1);
        applyStimulus(3, 3, 3);
        modelResolve();
        driveInputs();
        drain(50, "qos_priority");

        // Equal-qos streams alternate between VCs.
        for (int p = 0; p < 2; p++) begin
            applyStimulus(0, 2, 0);
            applyStimulus(1, 2, 0);
        end
        modelResolve();
        driveInputs();
        drain(100, "rr_tie");

        // Random packets with random disassembler backpressure.
        rand_ready = 1;
        for (int r = 0; r < 20; r++) begin
            for (int v = 0; v < NV; v++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) applyStimulus(v, $urandom_range(1, 4), $urandom_range(0, 3));
            end
            modelResolve();
            driveInputs();
            drain(2000, "random");
        end
        rand_ready = 0;

        // Long backpressure must not trip the watchdog.
        out_ready = 1'b0;
        applyStimulus(1, 3, 2);
        head = src_q[1][0];
        modelResolve();
        driveInputs();
        unstable = 0;
        repeat (500) begin
            tick();
            #2;
            if (out_valid && out_flit !== head) unstable++;
        end
        checkOutput("bp_flit_stable", 64'(unstable), 64'(0));
        checkOutput("bp_busy", 64'(busy), 64'(1));
        checkOutput("bp_grant", 64'(grant_vc), 64'(1));
        checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
        checkOutput("bp_out_flit", 64'(out_flit), 64'(head));
        out_ready = 1'b1;
        drain(50, "backpressure");

        // Watchdog: VC0 stalls after HEAD, VC1 SINGLE waits behind it.
        acc_cyc.delete();
        abort_cyc = -1;
        f.flit_type = FLIT_TYPE_HEAD;
        f.qos       = 2'd2;
        f.payload   = $urandom;
        src_q[0].push_back(f);
        e.flit = f;
        e.vc   = 0;
        exp_q.push_back(e);
        exp_err.push_back(ERR_TIMEOUT);
        f.flit_type = FLIT_TYPE_SINGLE;
        f.qos       = 2'd1;
        f.payload   = $urandom;
        src_q[1].push_back(f);
        e.flit = f;
        e.vc   = 1;
        exp_q.push_back(e);
        model_rr = 2;
        driveInputs();
        drain(700, "watchdog");
        checkOutput("wd_flit_count", 64'(acc_cyc.size()), 64'(2));
        if (acc_cyc.size() == 2) begin
            checkOutput("wd_abort_delay", 64'(abort_cyc - acc_cyc[0]), 64'(TO + 1));
            checkOutput("wd_next_grant", 64'(acc_cyc[1] - abort_cyc), 64'(1));
        end

        // Stray BODY in IDLE: popped at once, one protocol error next cycle.
        f.flit_type = FLIT_TYPE_BODY;
        f.qos       = 2'd0;
        f.payload   = $urandom;
        src_q[2].push_back(f);
        exp_err.push_back(ERR_PROTOCOL);
        driveInputs();
        #2;
        checkOutput("stray_in_ready", 64'(in_ready[2]), 64'(1));
        checkOutput("stray_out_valid", 64'(out_valid), 64'(0));
        drain(20, "stray");

        // Two strays in one cycle alongside a real HEAD: single error pulse.
        f.flit_type = FLIT_TYPE_TAIL;
        src_q[0].push_back(f);
        f.flit_type = FLIT_TYPE_BODY;
        src_q[3].push_back(f);
        exp_err.push_back(ERR_PROTOCOL);
        applyStimulus(1, 2, 0);
        modelResolve();
        driveInputs();
        drain(30, "multi_stray");

        // Reset mid-packet on VC1.
        out_ready = 1'b0;
        applyStimulus(1, 3, 0);
        for (int v = 0; v < NV; v++) mq[v].delete();
        driveInputs();
        repeat (5) tick();
        checkOutput("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #2;
        checkResetOutputs("mid_reset");
        for (int v = 0; v < NV; v++) src_q[v].delete();
        exp_q.delete();
        driveInputs();
        repeat (2) tick();
        rst_n = 1'b1;
        model_rr = 0;
        out_ready = 1'b1;
        for (int v = 0; v < NV; v++) applyStimulus(v, 1, 0);
        modelResolve();
        driveInputs();
        drain(50, "post_reset_rr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
